// File: rtl/serial_pattern_feeder_pkg.sv
// Shared definitions for the serial pattern feeder: FSM encoding and counter sizing.
package serial_pattern_feeder_pkg;

  // Two-state controller; kept as plain constants so older flows can reuse the encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit-counter width: max(1, clog2(width)).
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_pattern_feeder_if.sv
// Load handshake and serial output bundle of the serial pattern feeder.
interface serial_pattern_feeder_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  // Word source / serial consumer side.
  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  out_bit,
    input  out_valid,
    input  busy,
    input  done
  );

  // Feeder side.
  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output out_bit,
    output out_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/serial_pattern_feeder.sv
// Serializes parallel words, one bit per clock, onto a detector's serial input.
// A new word may be accepted while the last bit of the current one is on the line,
// giving a gapless stream across word boundaries.
module serial_pattern_feeder
  import serial_pattern_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_pattern_feeder_if.slave  bus
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load_ready;
  logic             accept;
  logic             last_bit;

  // bit_cnt==0 means the last bit is on the line, so the next word can slot in behind it.
  assign load_ready = (state_q == ST_IDLE) || (cnt_q == '0);
  assign accept     = bus.load_valid && load_ready;
  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == '0);

  assign bus.load_ready = load_ready;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Next-state: load on accept, otherwise shift the next bit out or fall back to idle.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = last_bit;

    if (accept) begin
      // The shift register keeps only the bits still to be sent, next one at the output end.
      if (MSB_FIRST) begin
        out_bit_d = bus.load_data[WIDTH-1];
        sreg_d    = bus.load_data << 1;
      end else begin
        out_bit_d = bus.load_data[0];
        sreg_d    = bus.load_data >> 1;
      end
      cnt_d       = CNT_LAST;
      out_valid_d = 1'b1;
      busy_d      = 1'b1;
      state_d     = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q != '0) begin
        if (MSB_FIRST) begin
          out_bit_d = sreg_q[WIDTH-1];
          sreg_d    = sreg_q << 1;
        end else begin
          out_bit_d = sreg_q[0];
          sreg_d    = sreg_q >> 1;
        end
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        out_bit_d   = IDLE_LEVEL;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        sreg_d      = '0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    end
  end

  // State and output registers; reset discards any partial word without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      out_bit_q   <= IDLE_LEVEL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: three instances (8-bit MSB-first, 8-bit LSB-first,
// 1-bit) driven in lockstep and compared against a bit-index reference model.
module tb_serial_pattern_feeder;

  typedef struct packed {
    int         w;
    bit         msb;
    logic [7:0] word;
    int         rem;   // bits of the current word still to appear after the one shown
    logic       b;
    logic       vld;
    logic       dn;
  } model_t;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       ex_rdy;
    logic       ex_bit;
    logic       ex_vld;
    logic       ex_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ld;
  logic       lv;

  int total = 0;
  int bad   = 0;

  model_t      mdl [3];
  logic        a_rdy [3];
  logic        a_bit [3];
  logic        a_vld [3];
  logic        a_bsy [3];
  logic        a_dn  [3];

  logic        acc0;
  logic [15:0] col0;
  int          vcnt0, dcnt0;
  logic [2:0]  hist;
  int          det_cnt;

  serial_pattern_feeder_if #(.WIDTH(8)) bus0 ();
  serial_pattern_feeder_if #(.WIDTH(8)) bus1 ();
  serial_pattern_feeder_if #(.WIDTH(1)) bus2 ();

  assign bus0.load_data  = ld;
  assign bus1.load_data  = ld;
  assign bus2.load_data  = ld[0];
  assign bus0.load_valid = lv;
  assign bus1.load_valid = lv;
  assign bus2.load_valid = lv;

  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );
  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );
  serial_pattern_feeder #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign a_rdy[0] = bus0.load_ready;
  assign a_rdy[1] = bus1.load_ready;
  assign a_rdy[2] = bus2.load_ready;
  assign a_bit[0] = bus0.out_bit;
  assign a_bit[1] = bus1.out_bit;
  assign a_bit[2] = bus2.out_bit;
  assign a_vld[0] = bus0.out_valid;
  assign a_vld[1] = bus1.out_valid;
  assign a_vld[2] = bus2.out_valid;
  assign a_bsy[0] = bus0.busy;
  assign a_bsy[1] = bus1.busy;
  assign a_bsy[2] = bus2.busy;
  assign a_dn[0]  = bus0.done;
  assign a_dn[1]  = bus1.done;
  assign a_dn[2]  = bus2.done;

  always #5 clk = ~clk;

  // Bit k of a word in transmission order.
  function automatic logic pick(model_t m, logic [7:0] wd, int k);
    return m.msb ? wd[m.w - 1 - k] : wd[k];
  endfunction

  function automatic model_t model_reset(model_t m);
    model_t n = m;
    n.word = '0;
    n.rem  = 0;
    n.b    = 1'b0;
    n.vld  = 1'b0;
    n.dn   = 1'b0;
    return n;
  endfunction

  function automatic model_t model_next(model_t m, logic [7:0] d, logic v);
    model_t n = m;
    n.dn = m.vld && (m.rem == 0);
    if (v && (m.rem == 0)) begin
      n.word = d;
      n.rem  = m.w - 1;
      n.vld  = 1'b1;
      n.b    = pick(m, d, 0);
    end else if (m.rem > 0) begin
      n.b   = pick(m, m.word, m.w - m.rem);
      n.rem = m.rem - 1;
    end else begin
      n.vld = 1'b0;
      n.b   = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance models at the edge, check outputs.
  task automatic tick(input logic [7:0] d, input logic v);
    logic rdy_m [3];
    ld = d;
    lv = v;
    #1;
    for (int i = 0; i < 3; i++) begin
      rdy_m[i] = (mdl[i].rem == 0);
      chk($sformatf("d%0d_ready", i), a_rdy[i], rdy_m[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mdl[i] = reset ? model_next(mdl[i], d, v) : model_reset(mdl[i]);
    end
    acc0 = v && rdy_m[0] && reset;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_out_bit", i), a_bit[i], mdl[i].b);
      chk($sformatf("d%0d_out_valid", i), a_vld[i], mdl[i].vld);
      chk($sformatf("d%0d_busy", i), a_bsy[i], mdl[i].vld);
      chk($sformatf("d%0d_done", i), a_dn[i], mdl[i].dn);
    end
    if (a_vld[0] === 1'b1) col0 = {col0[14:0], a_bit[0]};
    vcnt0 += (a_vld[0] === 1'b1) ? 1 : 0;
    dcnt0 += (a_dn[0] === 1'b1) ? 1 : 0;
    // Stand-in overlapping Mealy detector for 1011 on the LSB-first stream.
    if (a_vld[1] === 1'b1) begin
      if ({hist, a_bit[1]} == 4'b1011) det_cnt++;
      hist = {hist[1:0], a_bit[1]};
    end
  endtask

  vec_t       tbl [10];
  int         acc_at;
  logic [7:0] dw [3];
  int         widx;

  initial begin
    mdl[0] = '0; mdl[0].w = 8; mdl[0].msb = 1'b1;
    mdl[1] = '0; mdl[1].w = 8; mdl[1].msb = 1'b0;
    mdl[2] = '0; mdl[2].w = 1; mdl[2].msb = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = model_reset(mdl[i]);
    col0 = '0; vcnt0 = 0; dcnt0 = 0; hist = '0; det_cnt = 0; acc0 = 1'b0;

    // Single word 8'hB5 on the MSB-first instance: d, v, ready, bit, valid, done.
    tbl[0] = '{8'hB5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    ld = '0;
    lv = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    tick(8'h00, 1'b0);
    tick(8'h5A, 1'b1);  // ignored while in reset
    reset = 1'b1;
    tick(8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ld = tbl[i].d;
      lv = tbl[i].v;
      #1;
      chk($sformatf("tbl%0d_ready", i), a_rdy[0], tbl[i].ex_rdy);
      tick(tbl[i].d, tbl[i].v);
      chk($sformatf("tbl%0d_bit", i), a_bit[0], tbl[i].ex_bit);
      chk($sformatf("tbl%0d_valid", i), a_vld[0], tbl[i].ex_vld);
      chk($sformatf("tbl%0d_done", i), a_dn[0], tbl[i].ex_done);
    end

    // Back-to-back FF then 00: second accept in the last-bit cycle, 16 contiguous bits.
    col0 = '0; vcnt0 = 0; dcnt0 = 0; acc_at = -1;
    tick(8'hFF, 1'b1);
    for (int i = 1; i < 18; i++) begin
      tick(8'h00, (acc_at < 0) ? 1'b1 : 1'b0);
      if (acc0 && acc_at < 0) acc_at = i;
    end
    chk_int("b2b_accept_cycle", acc_at, 8);
    chk_int("b2b_valid_bits", vcnt0, 16);
    chk_int("b2b_done_pulses", dcnt0, 2);
    chk_int("b2b_stream", int'(col0), 16'hFF00);

    // Backpressure: AA held during 0F, taken only on the last bit.
    tick(8'h00, 1'b0);
    col0 = '0; vcnt0 = 0; dcnt0 = 0; acc_at = -1;
    tick(8'h0F, 1'b1);
    for (int i = 1; i < 18; i++) begin
      tick(8'hAA, (acc_at < 0) ? 1'b1 : 1'b0);
      if (acc0 && acc_at < 0) acc_at = i;
    end
    chk_int("bp_accept_cycle", acc_at, 8);
    chk_int("bp_stream", int'(col0), 16'h0FAA);
    chk_int("bp_done_pulses", dcnt0, 2);

    // Pattern 1011 inside one word and split across a boundary on the LSB-first stream.
    tick(8'h00, 1'b0);
    hist = '0; det_cnt = 0;
    dw[0] = 8'h0D; dw[1] = 8'h40; dw[2] = 8'h03;
    widx = 0;
    for (int i = 0; i < 30; i++) begin
      if (widx < 3 && mdl[1].rem == 0) begin
        tick(dw[widx], 1'b1);
        widx++;
      end else begin
        tick(8'h00, 1'b0);
      end
    end
    chk_int("det_hits", det_cnt, 2);

    // Asynchronous reset in the middle of F0, then a fresh word 81.
    tick(8'hF0, 1'b1);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    chk("mid_valid_before", a_vld[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_bit", a_bit[0], 1'b0);
    chk("arst_out_valid", a_vld[0], 1'b0);
    chk("arst_busy", a_bsy[0], 1'b0);
    chk("arst_done", a_dn[0], 1'b0);
    chk("arst_ready", a_rdy[0], 1'b1);
    for (int i = 0; i < 3; i++) mdl[i] = model_reset(mdl[i]);
    @(negedge clk);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    reset = 1'b1;
    col0 = '0; dcnt0 = 0;
    tick(8'h81, 1'b1);
    for (int i = 0; i < 9; i++) tick(8'h00, 1'b0);
    chk_int("post_reset_word", int'(col0[7:0]), 8'h81);
    chk_int("post_reset_done", dcnt0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(8'($urandom), ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
